// File: rtl/pipe_pc_link_chain.sv
// pipe_pc_link_chain
//   Carries each fetched PC through STAGES registered pipeline stages. Every
//   stage has a valid bit, a per-stage stall and a per-stage flush. The oldest
//   stage drives out_pc/out_valid and the JAL/JALR link address
//   (out_pc + LINK_OFFSET, or 0 when the stage is empty) to writeback.
//
// Parameters
//   WIDTH        PC / link-address width
//   STAGES       number of pipeline registers (>=1); stage 0 youngest
//   LINK_OFFSET  constant added to the oldest PC to form link_addr
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset (clears PCs and valids)
//   in_pc        PC presented by fetch
//   in_valid     in_pc is a real instruction
//   stall        bit i holds stage i (and every younger stage)
//   flush        bit i invalidates stage i at the next edge
//   stage_pc     flattened per-stage PCs, stage i at [i*WIDTH +: WIDTH]
//   stage_valid  per-stage valid bits
//   out_pc       PC of the oldest stage
//   out_valid    valid of the oldest stage
//   link_addr    out_valid ? out_pc + LINK_OFFSET : 0 (combinational)
//
// Optional feature (macro PIPE_PC_LINK_EPC_EN)
//   epc          PC of the oldest valid instruction killed by a flush
//   epc_valid    sticky flag: at least one capture since reset
module pipe_pc_link_chain #(
    parameter int          WIDTH       = 32,
    parameter int          STAGES      = 3,
    parameter int unsigned LINK_OFFSET = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_pc,
    input  logic                      in_valid,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic [WIDTH*STAGES-1:0]   stage_pc,
    output logic [STAGES-1:0]         stage_valid,
    output logic [WIDTH-1:0]          out_pc,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          link_addr
`ifdef PIPE_PC_LINK_EPC_EN
    ,
    output logic [WIDTH-1:0]          epc,
    output logic                      epc_valid
`endif
);

    // Link address wraps modulo 2^WIDTH; an empty stage yields zero.
    function automatic logic [WIDTH-1:0] link_calc(input logic [WIDTH-1:0] pc,
                                                   input logic             vld);
        if (vld)
            return pc + WIDTH'(LINK_OFFSET);
        else
            return '0;
    endfunction

    // A stall at any stage freezes every younger stage: hold[i] is the OR of
    // stall[i] and all older stall bits. Written without self-reference so the
    // vector has no combinational feedback on itself.
    logic [STAGES-1:0] hold;

    always_comb begin
        hold = '0;
        for (int i = 0; i < STAGES; i++)
            hold[i] = |(stall >> i);
    end

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            logic [WIDTH-1:0] pc_p;
            logic             vld_p;
            logic [WIDTH-1:0] pc_src;
            logic             vld_src;

            if (g == 0) begin : g_head
                assign pc_src  = in_pc;
                assign vld_src = in_valid;
            end else begin : g_body
                // Below a held stage the PC field is still copied, but the
                // valid bit drops so the stage receives a bubble.
                assign pc_src  = stage_pc[(g-1)*WIDTH +: WIDTH];
                assign vld_src = stage_valid[g-1] & ~hold[g-1];
            end

            // ---- stage g register boundary ----
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pc_p  <= '0;
                    vld_p <= 1'b0;
                end else begin
                    if (!hold[g])
                        pc_p <= pc_src;
                    // Flush wins over both hold and advance.
                    if (flush[g])
                        vld_p <= 1'b0;
                    else if (!hold[g])
                        vld_p <= vld_src;
                end
            end

            assign stage_pc[g*WIDTH +: WIDTH] = pc_p;
            assign stage_valid[g]             = vld_p;
        end
    endgenerate

    assign out_pc    = stage_pc[(STAGES-1)*WIDTH +: WIDTH];
    assign out_valid = stage_valid[STAGES-1];
    assign link_addr = link_calc(out_pc, out_valid);

`ifdef PIPE_PC_LINK_EPC_EN
    // Pick the oldest stage that is both valid and being flushed; the
    // ascending scan lets the highest index win.
    logic             cap_hit;
    logic [WIDTH-1:0] cap_pc;

    always_comb begin
        cap_hit = 1'b0;
        cap_pc  = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (flush[i] && stage_valid[i]) begin
                cap_hit = 1'b1;
                cap_pc  = stage_pc[i*WIDTH +: WIDTH];
            end
        end
    end

    // ---- exception PC capture boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc       <= '0;
            epc_valid <= 1'b0;
        end else if (cap_hit) begin
            epc       <= cap_pc;
            epc_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_pc_link_chain.sv
module tb_pipe_pc_link_chain;

    localparam int W = 32;
    localparam int S = 3;

    logic              clk;
    logic              reset;
    logic [W-1:0]      in_pc;
    logic              in_valid;
    logic [S-1:0]      stall;
    logic [S-1:0]      flush;
    logic [W*S-1:0]    stage_pc;
    logic [S-1:0]      stage_valid;
    logic [W-1:0]      out_pc;
    logic              out_valid;
    logic [W-1:0]      link_addr;
`ifdef PIPE_PC_LINK_EPC_EN
    logic [W-1:0]      epc;
    logic              epc_valid;
`endif

    // Single-stage instance for the one-edge latency corner
    logic [0:0]        stall1;
    logic [0:0]        flush1;
    logic [W-1:0]      stage_pc1;
    logic [0:0]        stage_valid1;
    logic [W-1:0]      out_pc1;
    logic              out_valid1;
    logic [W-1:0]      link_addr1;
`ifdef PIPE_PC_LINK_EPC_EN
    logic [W-1:0]      epc1;
    logic              epc_valid1;
`endif

    pipe_pc_link_chain #(.WIDTH(W), .STAGES(S), .LINK_OFFSET(8)) u0 (
        .clk(clk), .reset(reset), .in_pc(in_pc), .in_valid(in_valid),
        .stall(stall), .flush(flush), .stage_pc(stage_pc), .stage_valid(stage_valid),
        .out_pc(out_pc), .out_valid(out_valid), .link_addr(link_addr)
`ifdef PIPE_PC_LINK_EPC_EN
        , .epc(epc), .epc_valid(epc_valid)
`endif
    );

    pipe_pc_link_chain #(.WIDTH(W), .STAGES(1), .LINK_OFFSET(8)) u1 (
        .clk(clk), .reset(reset), .in_pc(in_pc), .in_valid(in_valid),
        .stall(stall1), .flush(flush1), .stage_pc(stage_pc1), .stage_valid(stage_valid1),
        .out_pc(out_pc1), .out_valid(out_valid1), .link_addr(link_addr1)
`ifdef PIPE_PC_LINK_EPC_EN
        , .epc(epc1), .epc_valid(epc_valid1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One record per clock edge: inputs driven before the edge, outputs
    // expected just after it.
    typedef struct packed {
        logic [W-1:0] pc;
        logic         vld;
        logic [S-1:0] stl;
        logic [S-1:0] fl;
        logic [W-1:0] e_pc;
        logic         e_vld;
        logic [W-1:0] e_link;
        logic [S-1:0] e_sv;
    } vec_t;

    localparam int NV = 19;
    vec_t vec [NV];

    initial begin
        // Stream 0x100.. with no stall: first PC reaches the output after edge 3
        vec[0]  = '{32'h100,      1'b1, 3'b000, 3'b000, 32'h0,        1'b0, 32'h0,   3'b001};
        vec[1]  = '{32'h104,      1'b1, 3'b000, 3'b000, 32'h0,        1'b0, 32'h0,   3'b011};
        vec[2]  = '{32'h108,      1'b1, 3'b000, 3'b000, 32'h100,      1'b1, 32'h108, 3'b111};
        vec[3]  = '{32'h10C,      1'b1, 3'b000, 3'b000, 32'h104,      1'b1, 32'h10C, 3'b111};
        vec[4]  = '{32'h110,      1'b1, 3'b000, 3'b000, 32'h108,      1'b1, 32'h110, 3'b111};
        // stall[1] for two cycles: stages 0/1 frozen, two bubbles into stage 2
        vec[5]  = '{32'h114,      1'b1, 3'b010, 3'b000, 32'h10C,      1'b0, 32'h0,   3'b011};
        vec[6]  = '{32'h118,      1'b1, 3'b010, 3'b000, 32'h10C,      1'b0, 32'h0,   3'b011};
        vec[7]  = '{32'h114,      1'b1, 3'b000, 3'b000, 32'h10C,      1'b1, 32'h114, 3'b111};
        vec[8]  = '{32'h118,      1'b1, 3'b000, 3'b000, 32'h110,      1'b1, 32'h118, 3'b111};
        vec[9]  = '{32'h200,      1'b1, 3'b000, 3'b000, 32'h114,      1'b1, 32'h11C, 3'b111};
        vec[10] = '{32'h204,      1'b1, 3'b000, 3'b000, 32'h118,      1'b1, 32'h120, 3'b111};
        vec[11] = '{32'h208,      1'b1, 3'b000, 3'b000, 32'h200,      1'b1, 32'h208, 3'b111};
        // flush[2] together with stall[2]: PC kept, valid dropped
        vec[12] = '{32'h20C,      1'b1, 3'b100, 3'b100, 32'h200,      1'b0, 32'h0,   3'b011};
        // flush[1] alone kills only stage 1
        vec[13] = '{32'h20C,      1'b1, 3'b000, 3'b010, 32'h204,      1'b1, 32'h20C, 3'b101};
        vec[14] = '{32'h0,        1'b0, 3'b000, 3'b000, 32'h208,      1'b0, 32'h0,   3'b010};
        vec[15] = '{32'h0,        1'b0, 3'b000, 3'b000, 32'h20C,      1'b1, 32'h214, 3'b100};
        // link address wrap
        vec[16] = '{32'hFFFFFFFC, 1'b1, 3'b000, 3'b000, 32'h0,        1'b0, 32'h0,   3'b001};
        vec[17] = '{32'h0,        1'b0, 3'b000, 3'b000, 32'h0,        1'b0, 32'h0,   3'b010};
        vec[18] = '{32'h0,        1'b0, 3'b000, 3'b000, 32'hFFFFFFFC, 1'b1, 32'h4,   3'b100};

        reset    = 1'b1;
        in_pc    = '0;
        in_valid = 1'b0;
        stall    = '0;
        flush    = '0;
        stall1   = '0;
        flush1   = '0;

        // Reset state (one clock edge elapses while reset is held)
        #12;
        chk("rst_out_pc",      128'(out_pc),      128'h0);
        chk("rst_out_valid",   128'(out_valid),   128'h0);
        chk("rst_link",        128'(link_addr),   128'h0);
        chk("rst_stage_pc",    128'(stage_pc),    128'h0);
        chk("rst_stage_valid", 128'(stage_valid), 128'h0);
        chk("rst_s1_out_pc",   128'(out_pc1),     128'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            in_pc    = vec[i].pc;
            in_valid = vec[i].vld;
            stall    = vec[i].stl;
            flush    = vec[i].fl;
            tick();
            chk($sformatf("v%0d_out_pc", i),      128'(out_pc),      128'(vec[i].e_pc));
            chk($sformatf("v%0d_out_valid", i),   128'(out_valid),   128'(vec[i].e_vld));
            chk($sformatf("v%0d_link", i),        128'(link_addr),   128'(vec[i].e_link));
            chk($sformatf("v%0d_stage_valid", i), 128'(stage_valid), 128'(vec[i].e_sv));
        end
        stall = '0;
        flush = '0;

        // Mid-stream asynchronous reset: fill the pipe, then reset between edges
        for (int i = 0; i < 3; i++) begin
            in_pc    = 32'h400 + 32'(4 * i);
            in_valid = 1'b1;
            tick();
        end
        chk("fill_stage_pc", 128'(stage_pc), 128'({32'h400, 32'h404, 32'h408}));
        chk("fill_valid",    128'(stage_valid), 128'h7);
        #3;
        reset = 1'b1;
        #1;
        chk("async_out_pc",      128'(out_pc),      128'h0);
        chk("async_link",        128'(link_addr),   128'h0);
        chk("async_stage_pc",    128'(stage_pc),    128'h0);
        chk("async_stage_valid", 128'(stage_valid), 128'h0);
        #2;
        reset = 1'b0;
        in_pc = 32'h500; in_valid = 1'b1; tick();
        in_pc = 32'h504;                  tick();
        chk("post_rst_2edges_valid", 128'(out_valid), 128'h0);
        in_pc = 32'h508;                  tick();
        chk("post_rst_out_pc",    128'(out_pc),    128'h500);
        chk("post_rst_out_valid", 128'(out_valid), 128'h1);

        // Stall on stage 0 only: stage 1 receives a bubble, stage 0 keeps 0x508
        in_pc = 32'h50C; stall = 3'b001; tick();
        chk("stall0_stage_valid", 128'(stage_valid), 128'b101);
        chk("stall0_s0_pc",       128'(stage_pc[0 +: W]), 128'h508);
        stall = '0;

        // STAGES=1: one-edge latency and wrap
        in_pc = 32'h700; in_valid = 1'b1; tick();
        chk("s1_out_pc",    128'(out_pc1),    128'h700);
        chk("s1_out_valid", 128'(out_valid1), 128'h1);
        chk("s1_link",      128'(link_addr1), 128'h708);
        in_pc = 32'hFFFFFFFC; tick();
        chk("s1_link_wrap", 128'(link_addr1), 128'h4);
        in_valid = 1'b0; tick();
        chk("s1_bubble_link", 128'(link_addr1), 128'h0);

`ifdef PIPE_PC_LINK_EPC_EN
        #3;
        reset = 1'b1;
        #1;
        chk("epc_rst",       128'(epc),       128'h0);
        chk("epc_valid_rst", 128'(epc_valid), 128'h0);
        #2;
        reset = 1'b0;
        in_valid = 1'b1;
        in_pc = 32'h2FC; tick();
        in_pc = 32'h300; tick();
        in_pc = 32'h304; tick();
        in_valid = 1'b0;
        flush = 3'b110; tick();
        chk("epc_capture",   128'(epc),       128'h2FC);
        chk("epc_valid_set", 128'(epc_valid), 128'h1);
        flush = 3'b100; tick();
        chk("epc_empty_flush",  128'(epc),       128'h2FC);
        chk("epc_valid_sticky", 128'(epc_valid), 128'h1);
        flush = '0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
